// File: rtl/mips_alu_md.sv
// MIPS execute-stage ALU: combinational integer ops plus an iterative multiply/divide
// unit that owns HI/LO. MULT/DIV take WIDTH+2 cycles from the start edge to done.
module mips_alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       control,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [5:0] OP_AND  = 6'h00, OP_OR   = 6'h01, OP_ADD  = 6'h02, OP_ADDU = 6'h03;
  localparam logic [5:0] OP_SUB  = 6'h06, OP_SUBU = 6'h07, OP_SLT  = 6'h08, OP_SLTU = 6'h09;
  localparam logic [5:0] OP_XOR  = 6'h0A, OP_NOR  = 6'h0B, OP_SLL  = 6'h0C, OP_SRL  = 6'h0D;
  localparam logic [5:0] OP_SRA  = 6'h0E, OP_MFHI = 6'h1C, OP_MFLO = 6'h1D, OP_MTHI = 6'h1E;
  localparam logic [5:0] OP_MTLO = 6'h1F;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state_reg, state_next;

  logic [SW-1:0]    cnt_reg;
  logic             div_reg, neg_res_reg, neg_rem_reg, div_zero_reg;
  logic [WIDTH-1:0] mag_b_reg, acc_hi_reg, acc_lo_reg, hi_reg, lo_reg;

  logic             is_md_code, accept, is_signed, sign1, sign2, last_iter;
  logic [WIDTH-1:0] mag1, mag2;

  // ---------------- combinational ALU ----------------
  logic [WIDTH-1:0] sum, diff;
  logic [SW-1:0]    shamt;

  assign sum   = src1 + src2;
  assign diff  = src1 - src2;
  assign shamt = src1[SW-1:0];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      OP_AND:  result = src1 & src2;
      OP_OR:   result = src1 | src2;
      OP_ADD: begin
        result   = sum;
        overflow = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_ADDU: result = sum;
      OP_SUB: begin
        result   = diff;
        overflow = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SUBU: result = diff;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (src1 < src2)};
      OP_XOR:  result = src1 ^ src2;
      OP_NOR:  result = ~(src1 | src2);
      OP_SLL:  result = src2 << shamt;
      OP_SRL:  result = src2 >> shamt;
      OP_SRA:  result = $unsigned($signed(src2) >>> shamt);
      OP_MFHI: result = hi_reg;
      OP_MFLO: result = lo_reg;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // ---------------- multiply/divide control ----------------
  assign busy       = (state_reg == RUN) || (state_reg == FIX);
  assign done       = (state_reg == DONE);
  assign is_md_code = (control[5:2] == 4'b0110);
  assign accept     = start && is_md_code && !busy;
  assign last_iter  = (cnt_reg == SW'(WIDTH-1));

  assign is_signed = ~control[0];
  assign sign1     = is_signed & src1[WIDTH-1];
  assign sign2     = is_signed & src2[WIDTH-1];
  assign mag1      = sign1 ? -src1 : src1;
  assign mag2      = sign2 ? -src2 : src2;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // One iteration: shift-add multiply, or restoring shift-subtract divide.
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, mag_b_reg} : '0);
  assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mag_b_reg});
  assign div_sub   = div_shift[WIDTH-1:0] - mag_b_reg;
  assign prod      = {acc_hi_reg, acc_lo_reg};
  assign prod_fix  = neg_res_reg ? -prod : prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      div_reg      <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      mag_b_reg    <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else if (accept) begin
      cnt_reg      <= '0;
      div_reg      <= control[1];
      neg_res_reg  <= sign1 ^ sign2;
      neg_rem_reg  <= sign1;
      div_zero_reg <= (src2 == '0);
      mag_b_reg    <= mag2;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= mag1;
    end else if (state_reg == RUN) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (div_reg) begin
        acc_hi_reg <= div_ge ? div_sub : div_shift[WIDTH-1:0];
        acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], div_ge};
      end else begin
        acc_hi_reg <= mul_sum[WIDTH:1];
        acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
      end
    end else if (state_reg == FIX) begin
      if (div_reg) begin
        // Divide by zero leaves quotient all ones; the remainder already equals src1.
        lo_reg <= div_zero_reg ? '1 : (neg_res_reg ? -acc_lo_reg : acc_lo_reg);
        hi_reg <= neg_rem_reg ? -acc_hi_reg : acc_hi_reg;
      end else begin
        {hi_reg, lo_reg} <= prod_fix;
      end
    end else if (start && !busy) begin
      if (control == OP_MTHI) hi_reg <= src1;
      if (control == OP_MTLO) lo_reg <= src1;
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: tb/tb_mips_alu_md.sv
// Self-checking bench for mips_alu_md: ALU table, multiply/divide scoreboard,
// busy interlock, reset abort and back-to-back issue.
`timescale 1ns/1ps
module tb_mips_alu_md;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [5:0]   control;
  logic [W-1:0] src1, src2, result, hi, lo;
  logic         zero, overflow, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] sb [$];

  mips_alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .control(control), .src1(src1), .src2(src2),
    .start(start), .result(result), .zero(zero), .overflow(overflow),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference arithmetic done in 64 bits so most-negative / -1 cannot trap.
  function automatic logic [63:0] model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, q, r;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    case (c)
      6'h18: return sa * sbv;
      6'h19: return {32'h0, a} * {32'h0, b};
      6'h1A: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      6'h1B: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic issue_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    control = c; src1 = a; src2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int nbusy, output bit to);
    lat   = lat0;
    nbusy = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
    end
    to = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; control = 6'h00; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: busy=%b done=%b required 0 0", busy, done);
    end
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  localparam int NA = 16;
  logic [5:0]  alu_c [NA];
  logic [31:0] alu_a [NA];
  logic [31:0] alu_b [NA];
  logic [31:0] alu_r [NA];
  logic        alu_v [NA];

  task automatic test_alu();
    alu_c = '{6'h02, 6'h03, 6'h06, 6'h06, 6'h07, 6'h00, 6'h01, 6'h0A,
              6'h0B, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h18};
    alu_a = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'hF0F0_F0F0,
              32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'h24, 32'h8, 32'h8, 32'h1, 32'h3};
    alu_b = '{32'h1, 32'h1, 32'd5, 32'h1, 32'h1, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00,
              32'hFF00_FF00, 32'h1, 32'h1, 32'hF, 32'h8000_0000, 32'h8000_0000, 32'h2, 32'h4};
    alu_r = '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hF000_F000,
              32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h000F_000F, 32'h1, 32'h0, 32'hF0,
              32'h0080_0000, 32'hFF80_0000, 32'h0, 32'h0};
    alu_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    start = 1'b0;
    for (int i = 0; i < NA; i++) begin
      control = alu_c[i]; src1 = alu_a[i]; src2 = alu_b[i];
      #1;
      n_cmp++;
      if (result !== alu_r[i]) begin
        n_err++;
        $display("FAIL alu_result[%0d]: got %h required %h", i, result, alu_r[i]);
      end
      n_cmp++;
      if (zero !== (alu_r[i] == 32'h0)) begin
        n_err++;
        $display("FAIL alu_zero[%0d]: got %b required %b", i, zero, (alu_r[i] == 32'h0));
      end
      n_cmp++;
      if (overflow !== alu_v[i]) begin
        n_err++;
        $display("FAIL alu_overflow[%0d]: got %b required %b", i, overflow, alu_v[i]);
      end
      $display("alu[%0d] ctrl=%h a=%h b=%h -> result=%h zero=%b ovf=%b", i, alu_c[i], alu_a[i], alu_b[i], result, zero, overflow);
      @(negedge clk);
    end
  endtask

  // Multiply/divide table; each entry is checked for value, latency, busy span and done width.
  task automatic test_md(input string name, input logic [5:0] c [4], input logic [31:0] a [4],
                         input logic [31:0] b [4], input logic [63:0] e [4]);
    int lat, nb;
    bit to;
    logic [63:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(e[i]);
      issue_op(c[i], a[i], b[i]);
      wait_done(1, lat, nb, to);
      exp_v = sb.pop_front();
      n_cmp++;
      if (to || {hi, lo} !== exp_v) begin
        n_err++;
        $display("FAIL %s[%0d] value: hi_lo=%h timeout=%0b required %h", name, i, {hi, lo}, to, exp_v);
      end
      n_cmp++;
      if (lat != LAT || nb != W + 1) begin
        n_err++;
        $display("FAIL %s[%0d] timing: latency=%0d busy_cycles=%0d required %0d %0d", name, i, lat, nb, LAT, W + 1);
      end
      $display("%s[%0d] ctrl=%h a=%h b=%h -> hi=%h lo=%h lat=%0d", name, i, c[i], a[i], b[i], hi, lo, lat);
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s[%0d] done_pulse: done=%b busy=%b required 0 0", name, i, done, busy);
      end
    end
  endtask

  task automatic test_mult();
    test_md("mult", '{6'h18, 6'h19, 6'h18, 6'h19},
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000},
            '{32'h2, 32'h2, 32'h8000_0000, 32'h0001_0000},
            '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_FFFF_FFFE, 64'h4000_0000_0000_0000, 64'h0000_0001_0000_0000});
  endtask

  task automatic test_div();
    test_md("div", '{6'h1A, 6'h1B, 6'h1A, 6'h1A},
            '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7},
            '{32'h2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E, 64'h0000_0000_8000_0000, 64'h0000_0001_FFFF_FFFD});
  endtask

  task automatic test_div_zero();
    test_md("divzero", '{6'h1B, 6'h1A, 6'h1A, 6'h1B},
            '{32'h1234, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFF},
            '{32'h0, 32'h0, 32'h0, 32'h0},
            '{64'h0000_1234_FFFF_FFFF, 64'hFFFF_FFFB_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF});
  endtask

  task automatic test_random();
    logic [5:0]  c [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [63:0] e [4];
    for (int i = 0; i < 4; i++) begin
      c[i] = 6'(6'h18 + $urandom_range(0, 3));
      a[i] = $urandom;
      b[i] = (i[0]) ? 32'($urandom_range(1, 1000)) : $urandom;
      e[i] = model(c[i], a[i], b[i]);
    end
    test_md("rand", c, a, b, e);
  endtask

  task automatic test_busy_ignore();
    int lat, nb;
    bit to;
    logic [63:0] exp_v;
    issue_op(6'h1F, 32'h5A5A, 32'h0);
    n_cmp++;
    if (lo !== 32'h5A5A || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mtlo: lo=%h done=%b busy=%b required 00005a5a 0 0", lo, done, busy);
    end
    $display("mtlo a=00005a5a -> lo=%h", lo);
    sb.push_back(64'h0000_0000_0000_000C);
    issue_op(6'h18, 32'd3, 32'd4);
    control = 6'h1A; src1 = 32'd100; src2 = 32'd3; start = 1'b1;
    @(negedge clk);
    control = 6'h1F; src1 = 32'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0; control = 6'h1D;
    #1;
    n_cmp++;
    if (result !== 32'h5A5A || busy !== 1'b1) begin
      n_err++;
      $display("FAIL mflo_busy: result=%h busy=%b required 00005a5a 1", result, busy);
    end
    wait_done(3, lat, nb, to);
    exp_v = sb.pop_front();
    n_cmp++;
    if (to || {hi, lo} !== exp_v || lat != LAT) begin
      n_err++;
      $display("FAIL busy_ignore: hi_lo=%h latency=%0d required %h %0d", {hi, lo}, lat, exp_v, LAT);
    end
    $display("mult 3*4 with ignored starts -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    issue_op(6'h1E, 32'hAB, 32'h0);
    n_cmp++;
    if (hi !== 32'hAB || lo !== 32'hC || done !== 1'b0) begin
      n_err++;
      $display("FAIL mthi: hi=%h lo=%h done=%b required 000000ab 0000000c 0", hi, lo, done);
    end
    control = 6'h1C; #1;
    n_cmp++;
    if (result !== 32'hAB) begin
      n_err++;
      $display("FAIL mfhi: result=%h required 000000ab", result);
    end
    $display("mthi a=000000ab -> hi=%h mfhi=%h", hi, result);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, nb;
    bit to;
    logic [63:0] exp_v;
    issue_op(6'h18, 32'd5, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    $display("reset mid-mult -> busy=%b hi=%h lo=%h", busy, hi, lo);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back(64'd42);
    issue_op(6'h18, 32'd6, 32'd7);
    wait_done(1, lat, nb, to);
    exp_v = sb.pop_front();
    n_cmp++;
    if (to || {hi, lo} !== exp_v || lat != LAT) begin
      n_err++;
      $display("FAIL after_reset: hi_lo=%h latency=%0d required %h %0d", {hi, lo}, lat, exp_v, LAT);
    end
    $display("mult 6*7 after reset -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    bit to;
    logic [63:0] exp_v;
    sb.push_back(64'hFFFF_FFFE_0000_0001);
    sb.push_back(64'h0000_0000_0000_0064);
    issue_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, lat, nb, to);
    exp_v = sb.pop_front();
    n_cmp++;
    if (to || {hi, lo} !== exp_v) begin
      n_err++;
      $display("FAIL b2b_first: hi_lo=%h required %h", {hi, lo}, exp_v);
    end
    $display("b2b multu -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    issue_op(6'h1B, 32'd1000, 32'd10);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: done=%b busy=%b required 0 1", done, busy);
    end
    wait_done(1, lat, nb, to);
    exp_v = sb.pop_front();
    n_cmp++;
    if (to || {hi, lo} !== exp_v || lat != LAT) begin
      n_err++;
      $display("FAIL b2b_second: hi_lo=%h latency=%0d required %h %0d", {hi, lo}, lat, exp_v, LAT);
    end
    $display("b2b divu -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_div_zero();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_alu_md.md
Name: mips_alu_md

Overview:
Parametrised next-generation MIPS execute-stage ALU. It provides the full single-cycle integer operation set with zero and overflow flags. It adds an iterative multi-cycle multiply/divide unit that owns the HI/LO registers. The datapath controller issues operations and stalls on busy.

Parameters:
WIDTH, 32, datapath width in bits; even, >= 8; shift amount uses the low $clog2(WIDTH) bits of src1.

Ports:
clk      input   1      rising-edge clock
rst_n    input   1      asynchronous, active-low reset
control  input   6      operation code (encoding below)
src1     input   WIDTH  operand A; also the shift amount for shift ops
src2     input   WIDTH  operand B
start    input   1      issue strobe for HI/LO ops (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
result   output  WIDTH  combinational result
zero     output  1      result == 0
overflow output  1      signed overflow (ADD/SUB only)
busy     output  1      multiply/divide in progress
done     output  1      one-cycle pulse; HI/LO hold the new values
hi       output  WIDTH  HI register
lo       output  WIDTH  LO register

Behaviour:
- Encoding:
  - 00 AND; 01 OR; 02 ADD; 03 ADDU; 06 SUB; 07 SUBU; 08 SLT (signed); 09 SLTU.
  - 0A XOR; 0B NOR; 0C SLL (src2<<sh); 0D SRL; 0E SRA.
  - 18 MULT; 19 MULTU; 1A DIV; 1B DIVU; 1C MFHI; 1D MFLO; 1E MTHI; 1F MTLO.
  - Any other code: result=0.
- result, zero and overflow are purely combinational on the current inputs.
  - MFHI/MFLO return the current hi/lo, including stale values while busy; the external interlock handles this.
  - Codes 18–1B and 1E–1F give result=0.
  - SLT/SLTU give result 1 or 0, zero-extended.
- overflow=1 only for ADD/SUB on signed overflow. ADDU/SUBU never flag. Results wrap modulo 2^WIDTH.
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset mid-operation aborts the operation; no HI/LO write occurs.
- FSM states are IDLE, RUN, FIX, DONE.
  - IDLE/DONE + start + code 18–1B:
    - src1/src2 are captured.
    - Signed ops take operand magnitudes and record the signs.
    - Next state is RUN with counter=0.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle. After WIDTH iterations the FSM goes to FIX.
  - FIX, one cycle:
    - MULT: product negated if the signs differ.
    - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend.
    - hi/lo are written at the FIX->DONE edge.
  - DONE: done=1 for exactly one cycle, then IDLE, unless a new start is accepted, which goes to RUN (back-to-back issue allowed).
- Timing:
  - busy=1 in RUN and FIX.
  - Start sampled at edge 0 gives done=1 in the cycle following edge WIDTH+1.
- Results:
  - MULT/MULTU: {hi,lo} = 2*WIDTH-bit product.
  - DIV/DIVU: lo=quotient, hi=remainder; quotient truncates toward zero.
- Divide by zero, signed or unsigned: lo=all ones, hi=src1 as captured, no exception, same latency.
- Most-negative / -1: lo=most-negative value, hi=0 (wraps naturally).
- MTHI/MTLO: with start=1 and the FSM not busy, hi (or lo) <= src1 at the edge. done is not asserted.
- start is ignored while busy=1. start with any non-HI/LO code is ignored.
- MTHI/MTLO while busy are dropped; the running operation is unaffected.
- Operand changes after the start edge do not affect an in-flight operation.

Test Plan:
1. ADD 0x7FFFFFFF + 0x00000001 -> result=0x80000000, overflow=1, zero=0. ADDU with the same operands -> overflow=0. SUB 5-5 -> result=0, zero=1.
2. MULT src1=0xFFFFFFFF, src2=0x00000002 with a start pulse -> busy for 33 cycles, done one cycle later, hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234, done at the normal latency.
5. Start MULT 3*4, then pulse start with DIV and with MTLO mid-run -> both ignored; final hi=0, lo=12. MFLO issued mid-run returns the old lo. MTHI src1=0xAB after done -> hi=0xAB.
6. Start MULT, assert rst_n=0 at iteration 10 -> busy=0, done=0, hi=lo=0 immediately. After release, a new MULT 6*7 gives lo=42.
